mdu_e: RTL
==========

# mdu_e

Execute-stage multiply/divide unit for the pipelined MIPS core. Sits beside the ALU and receives the same forwarded operands. It runs MULT/MULTU/DIV/DIVU as multi-cycle operations into private HI/LO registers and services MTHI/MTLO/MFHI/MFLO. Its read result feeds the E-stage result mux alongside the ALU output. It exports busy/start so the hazard unit can stall D-stage multiply/divide instructions.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- a  in  32  forwarded rs operand
- b  in  32  forwarded rt operand
- mdop  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9–15 treated as none
- cancel  in  1  exception/interrupt flush in a later stage; suppresses issue of the E-stage instruction this cycle
- start  out  1  combinational; 1 when mdop∈{1..4}, !cancel and !busy
- busy  out  1  registered; operation in flight
- hi  out  32  architectural HI register
- lo  out  32  architectural LO register
- out  out  32  combinational: hi when mdop=7, lo when mdop=8, else 0

## Operation
- State: hi, lo, busy, 4-bit down-counter cnt, and result registers res_hi/res_lo captured at issue.
- Issue (mdop 1–4, !cancel, !busy) at edge T:
  - MULT: {res_hi,res_lo} = signed 64-bit a×b.
  - MULTU: unsigned 64-bit a×b.
  - DIV: res_lo = signed quotient, truncated toward zero; res_hi = remainder, sign of dividend.
  - DIVU: unsigned quotient and remainder.
  - busy←1; cnt←MULT_CYCLES−1 or DIV_CYCLES−1.
- In flight: cnt decrements each edge while busy. At the edge where busy=1 and cnt=0: hi←res_hi, lo←res_lo, busy←0.
- Divide by zero (b=0, DIV or DIVU): busy sequence runs normally; hi/lo are left unchanged at completion (an internal flag suppresses the write).
- MTHI/MTLO (!cancel, !busy): hi←a or lo←a at the edge. While busy they are ignored; the hazard unit must stall them.
- mdop 1–6 while busy: ignored, with no effect on state.
- MFHI/MFLO: pure reads of current hi/lo. While busy they return the old values; the hazard unit stalls them.
- cancel=1: no issue and no MTHI/MTLO write. cancel does not abort an operation already in flight; it completes and writes.
- Reset (async, any time, including mid-operation): hi=0, lo=0, busy=0, cnt=0, res_hi=0, res_lo=0, div-by-zero flag=0. The in-flight result is discarded.

## Timing
- Reset values: busy=0, hi=0, lo=0, out=0 (mdop=0), start=0 (mdop=0).
- Issue edge T: busy reads 1 from T through T+N−1 (N = MULT_CYCLES/DIV_CYCLES). It falls at edge T+N, the same edge that updates hi/lo.
- An operation issued at edge T is visible to MFHI/MFLO in the cycle after edge T+N.
- Back-to-back: a new mult/div can issue at edge T+N only if the stall has released. Since busy=1 in the cycle before T+N, earliest issue is edge T+N+1. There is no overlap.
- start is combinational from mdop/cancel/busy. The hazard unit uses (busy | start) to stall D-stage instructions with mdop 1–8.
- MTHI/MTLO take effect at the issuing edge, so hi/lo is visible next cycle.
- N=1 edge case: busy high for exactly one cycle.

## Test plan
- Reset, then MULT with a=0xFFFFFFFF, b=2 -> busy 1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- MTHI a=0x12345678, then DIVU a=5, b=0 -> busy for 10 cycles; hi still 0x12345678 and lo unchanged after completion.
- MULT issued, then MTLO/MULT presented while busy -> ignored; start=0 throughout busy; only the first result appears. MFLO during busy -> out=old lo.
- MULT with cancel=1 -> start=0, busy stays 0, hi/lo unchanged. MTHI with cancel=1 -> hi unchanged.
- DIV issued, reset asserted asynchronously at busy cycle 4 -> busy, hi, lo read 0 immediately. After release, no late write occurs in the following 10 cycles.

Source files
------------

// File: rtl/mdu_e.sv
// ---------------------------------------------------------------------------
// mdu_e : execute-stage multiply/divide unit
//
// Runs MULT/MULTU/DIV/DIVU as fixed-latency operations into private HI/LO
// registers and services MTHI/MTLO/MFHI/MFLO. The full 64-bit result is
// computed when the operation issues and parked in res_hi/res_lo. A down
// counter then holds busy for the programmed number of cycles before the
// result is committed to HI/LO.
//
// Ports
//   clk     in   1   rising-edge clock
//   reset   in   1   asynchronous, active-high; clears all state
//   a       in  32   forwarded rs operand
//   b       in  32   forwarded rt operand
//   mdop    in   4   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                    5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9-15 none
//   cancel  in   1   flush from a later stage; blocks issue and MTHI/MTLO
//   start   out  1   combinational; a mult/div issues on this edge
//   busy    out  1   registered; operation in flight
//   hi      out 32   architectural HI
//   lo      out 32   architectural LO
//   out     out 32   combinational read port (MFHI/MFLO), else 0
// ---------------------------------------------------------------------------
module mdu_e #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  mdop,
    input  logic        cancel,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] out
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdop_e;

    // The counter is loaded with N-1 so that busy spans exactly N cycles.
    localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Arithmetic helpers
    // -----------------------------------------------------------------------

    // Signed 32x32 -> 64 product.
    function automatic logic [63:0] f_mul_s(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] xs;
        logic signed [63:0] ys;
        xs = {{32{x[31]}}, x};
        ys = {{32{y[31]}}, y};
        return xs * ys;
    endfunction

    // Unsigned 32x32 -> 64 product.
    function automatic logic [63:0] f_mul_u(input logic [31:0] x, input logic [31:0] y);
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Unsigned divide, returns {remainder, quotient}. A zero divisor is
    // replaced by one so the datapath stays defined; the caller suppresses
    // the write-back in that case anyway.
    function automatic logic [63:0] f_div_u(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ys;
        ys = (y == 32'd0) ? 32'd1 : y;
        return {x % ys, x / ys};
    endfunction

    // Signed divide on magnitudes: quotient truncates toward zero and its
    // sign is the XOR of the operand signs; the remainder takes the sign of
    // the dividend. -2^31 / -1 wraps to 0x80000000 with remainder 0.
    function automatic logic [63:0] f_div_s(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] mx;
        logic [31:0] my;
        logic [63:0] rq;
        logic [31:0] q;
        logic [31:0] r;
        mx = x[31] ? (32'd0 - x) : x;
        my = y[31] ? (32'd0 - y) : y;
        rq = f_div_u(mx, my);
        q  = (x[31] ^ y[31]) ? (32'd0 - rq[31:0]) : rq[31:0];
        r  = x[31] ? (32'd0 - rq[63:32]) : rq[63:32];
        return {r, q};
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_dz;

    logic        w_is_md;
    logic        w_issue;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_dz;
    logic [63:0] w_res;
    logic [3:0]  w_cnt_init;
    logic [31:0] w_out;

    // Decode of the issuing instruction.
    always_comb begin
        w_is_md = (mdop >= OP_MULT) && (mdop <= OP_DIVU);
        w_issue = w_is_md && !cancel && !r_busy;
        w_mthi  = (mdop == OP_MTHI) && !cancel;
        w_mtlo  = (mdop == OP_MTLO) && !cancel;
    end

    // Result, counter preload and divide-by-zero flag for the issuing op.
    always_comb begin
        w_res      = 64'd0;
        w_cnt_init = LP_MULT_CNT;
        w_dz       = 1'b0;
        case (mdop)
            OP_MULT: begin
                w_res = f_mul_s(a, b);
            end
            OP_MULTU: begin
                w_res = f_mul_u(a, b);
            end
            OP_DIV: begin
                w_res      = f_div_s(a, b);
                w_cnt_init = LP_DIV_CNT;
                w_dz       = (b == 32'd0);
            end
            OP_DIVU: begin
                w_res      = f_div_u(a, b);
                w_cnt_init = LP_DIV_CNT;
                w_dz       = (b == 32'd0);
            end
            default: begin
                w_res      = 64'd0;
                w_cnt_init = LP_MULT_CNT;
                w_dz       = 1'b0;
            end
        endcase
    end

    // Read port: MFHI/MFLO return the committed registers, even while busy.
    always_comb begin
        w_out = 32'd0;
        case (mdop)
            OP_MFHI: w_out = r_hi;
            OP_MFLO: w_out = r_lo;
            default: w_out = 32'd0;
        endcase
    end

    // HI/LO, in-flight result, busy and latency counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_cnt    <= 4'd0;
            r_busy   <= 1'b0;
            r_dz     <= 1'b0;
        end else if (r_busy) begin
            // All new requests are ignored while busy; cancel does not abort.
            if (r_cnt == 4'd0) begin
                r_busy <= 1'b0;
                if (!r_dz) begin
                    r_hi <= r_res_hi;
                    r_lo <= r_res_lo;
                end
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end else if (w_issue) begin
            r_res_hi <= w_res[63:32];
            r_res_lo <= w_res[31:0];
            r_cnt    <= w_cnt_init;
            r_dz     <= w_dz;
            r_busy   <= 1'b1;
        end else if (w_mthi) begin
            r_hi <= a;
        end else if (w_mtlo) begin
            r_lo <= a;
        end
    end

    assign start = w_issue;
    assign busy  = r_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign out   = w_out;

endmodule
